// File: rtl/iagc_cmd_pkg.sv
// Shared definitions for the IAGC command controller: opcodes, reply bytes,
// FSM states and the STATUS reply layout.
package iagc_cmd_pkg;

    localparam logic [1:0] OP_PING     = 2'b00;
    localparam logic [1:0] OP_SET_GAIN = 2'b01;
    localparam logic [1:0] OP_SAMPLE   = 2'b10;
    localparam logic [1:0] OP_STATUS   = 2'b11;

    localparam logic [7:0] REPLY_PING = 8'hA5;
    localparam logic [7:0] REPLY_ERR  = 8'hEE;

    localparam int STAT_ADC_BIT = 7;
    localparam int STAT_OVR_BIT = 6;
    localparam int STAT_TO_BIT  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_ADC,
        ST_SAMPLE_WAIT,
        ST_TX_LOAD,
        ST_TX_WAIT
    } state_e;

    function automatic logic [7:0] status_byte(input logic adcDone,
                                               input logic overrun,
                                               input logic timeoutSeen);
        logic [7:0] s;
        s               = '0;
        s[STAT_ADC_BIT] = adcDone;
        s[STAT_OVR_BIT] = overrun;
        s[STAT_TO_BIT]  = timeoutSeen;
        return s;
    endfunction

endpackage

// File: rtl/iagc_rx_hold.sv
// One-entry receive holding register. A byte arriving while the entry is
// occupied (and not being released this cycle) is dropped and flags overrun.
module iagc_rx_hold (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       release_i,
    input  logic       clear_overrun_i,
    output logic       full_o,
    output logic [7:0] data_o,
    output logic       overrun_o
);

    logic       full_q, full_d;
    logic [7:0] data_q, data_d;
    logic       overrun_q, overrun_d;
    logic       accept;

    always_comb begin
        accept    = rx_valid_i && (!full_q || release_i);
        full_d    = full_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (release_i) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            data_d = rx_data_i;
        end
        if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end
        if (rx_valid_i && !accept) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign full_o    = full_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/iagc_cmd_ctrl.sv
// Host command controller: decodes UART command bytes, owns the gain register,
// requests ADC samples and streams replies into uart_tx.
// Optional sample-wait timeout: define IAGC_CMD_TIMEOUT_EN.
module iagc_cmd_ctrl
    import iagc_cmd_pkg::*;
#(
    parameter int unsigned SAMPLE_W       = 16,
    parameter int unsigned GAIN_W         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1250000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_ready,
    input  logic                i_adc_init_done,
    output logic                o_sample_req,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample_data,
    output logic [GAIN_W-1:0]   o_gain,
    output logic                o_busy
);

    state_e            state_q, state_d;
    logic [7:0]        txData_q, txData_d;
    logic [7:0]        byte2_q, byte2_d;
    logic              pending_q, pending_d;
    logic              seenLow_q, seenLow_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              sampleReq_q, sampleReq_d;

    logic              holdFull, holdOverrun, holdRelease, clearFlags;
    logic [7:0]        holdData;
    logic [15:0]       sampleWide;
    logic              expired;
    logic              timeoutSeen;

    assign sampleWide = 16'(i_sample_data);

    iagc_rx_hold u_rx_hold (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data_i       (i_rx_data),
        .rx_valid_i      (i_rx_valid),
        .release_i       (holdRelease),
        .clear_overrun_i (clearFlags),
        .full_o          (holdFull),
        .data_o          (holdData),
        .overrun_o       (holdOverrun)
    );

`ifdef IAGC_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             waiting, progress;

    // Counter restarts from zero on every entry into WAIT_ADC.
    assign waiting  = (state_q == ST_WAIT_ADC) || (state_q == ST_SAMPLE_WAIT);
    assign progress = (state_q == ST_WAIT_ADC) ? i_adc_init_done : i_sample_valid;
    assign expired  = waiting && !progress && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= waiting ? cnt_q + 1'b1 : '0;
            timeout_q <= expired || (timeout_q && !clearFlags);
        end
    end

    assign timeoutSeen = timeout_q;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign expired     = 1'b0;
    assign timeoutSeen = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        txData_d    = txData_q;
        byte2_d     = byte2_q;
        pending_d   = pending_q;
        seenLow_d   = seenLow_q;
        gain_d      = gain_q;
        o_tx_start  = 1'b0;
        holdRelease = 1'b0;
        clearFlags  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (holdFull || i_rx_valid) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                holdRelease = 1'b1;
                pending_d   = 1'b0;
                case (holdData[7:6])
                    OP_PING: begin
                        txData_d = REPLY_PING;
                        state_d  = ST_TX_LOAD;
                    end
                    OP_SET_GAIN: begin
                        gain_d   = holdData[GAIN_W-1:0];
                        txData_d = holdData;
                        state_d  = ST_TX_LOAD;
                    end
                    OP_SAMPLE: begin
                        state_d = ST_WAIT_ADC;
                    end
                    OP_STATUS: begin
                        txData_d   = status_byte(i_adc_init_done, holdOverrun, timeoutSeen);
                        clearFlags = 1'b1;
                        state_d    = ST_TX_LOAD;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_WAIT_ADC: begin
                if (i_adc_init_done) begin
                    state_d = ST_SAMPLE_WAIT;
                end else if (expired) begin
                    txData_d = REPLY_ERR;
                    state_d  = ST_TX_LOAD;
                end
            end
            ST_SAMPLE_WAIT: begin
                if (i_sample_valid) begin
                    txData_d  = sampleWide[15:8];
                    byte2_d   = sampleWide[7:0];
                    pending_d = 1'b1;
                    state_d   = ST_TX_LOAD;
                end else if (expired) begin
                    txData_d = REPLY_ERR;
                    state_d  = ST_TX_LOAD;
                end
            end
            ST_TX_LOAD: begin
                if (i_tx_ready) begin
                    o_tx_start = 1'b1;
                    seenLow_d  = 1'b0;
                    state_d    = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                // A byte is only finished once uart_tx has gone busy and come back.
                if (!i_tx_ready) begin
                    seenLow_d = 1'b1;
                end else if (seenLow_q) begin
                    if (pending_q) begin
                        txData_d  = byte2_q;
                        pending_d = 1'b0;
                        state_d   = ST_TX_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sampleReq_d = (state_d == ST_SAMPLE_WAIT) && (state_q != ST_SAMPLE_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            txData_q    <= '0;
            byte2_q     <= '0;
            pending_q   <= 1'b0;
            seenLow_q   <= 1'b0;
            gain_q      <= '0;
            sampleReq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            txData_q    <= txData_d;
            byte2_q     <= byte2_d;
            pending_q   <= pending_d;
            seenLow_q   <= seenLow_d;
            gain_q      <= gain_d;
            sampleReq_q <= sampleReq_d;
        end
    end

    assign o_tx_data    = txData_q;
    assign o_sample_req = sampleReq_q;
    assign o_gain       = gain_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iagc_cmd_ctrl.sv
// Self-checking bench for iagc_cmd_ctrl: behavioural uart_tx and ADC models plus
// a reply-queue reference model driven by directed and random commands.
module tb_iagc_cmd_ctrl;

    localparam int SAMPLE_W       = 16;
    localparam int GAIN_W         = 6;
    localparam int TIMEOUT_CYCLES = 100;
`ifdef IAGC_CMD_TIMEOUT_EN
    localparam int PRE_INIT_WAIT  = 50;
`else
    localparam int PRE_INIT_WAIT  = 1000;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          i_rx_data = '0;
    logic                i_rx_valid = 1'b0;
    logic [7:0]          o_tx_data;
    logic                o_tx_start;
    logic                i_tx_ready;
    logic                i_adc_init_done = 1'b0;
    logic                o_sample_req;
    logic                i_sample_valid;
    logic [SAMPLE_W-1:0] i_sample_data;
    logic [GAIN_W-1:0]   o_gain;
    logic                o_busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  expQ[$];
    logic [5:0]  modelGain = '0;
    logic        modelOverrun = 1'b0;
    logic        modelTimeout = 1'b0;
    logic [15:0] nextSample = '0;
    int          txBusy = 3;
    int          adcDelay = 2;
    bit          adcEnable = 1'b1;
    int          startCount = 0;
    int          reqCount = 0;
    logic [7:0]  txByte;
    logic [5:0]  oldGain;
    int          r0, s0;
    bit          seen;

    iagc_cmd_ctrl #(
        .SAMPLE_W       (SAMPLE_W),
        .GAIN_W         (GAIN_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_rx_data       (i_rx_data),
        .i_rx_valid      (i_rx_valid),
        .o_tx_data       (o_tx_data),
        .o_tx_start      (o_tx_start),
        .i_tx_ready      (i_tx_ready),
        .i_adc_init_done (i_adc_init_done),
        .o_sample_req    (o_sample_req),
        .i_sample_valid  (i_sample_valid),
        .i_sample_data   (i_sample_data),
        .o_gain          (o_gain),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Caller must sit just after a rising edge; the byte occupies exactly one cycle.
    task automatic driveRx(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge clk);
        #1 i_rx_valid = 1'b0;
    endtask

    // Reference model: the reply each command must produce, from the command rules alone.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [15:0] sampleVal);
        case (cmd[7:6])
            2'b00: expQ.push_back(8'hA5);
            2'b01: begin
                modelGain = cmd[5:0];
                expQ.push_back(cmd);
            end
            2'b10: begin
                nextSample = sampleVal;
                expQ.push_back(sampleVal[15:8]);
                expQ.push_back(sampleVal[7:0]);
            end
            default: begin
                expQ.push_back({i_adc_init_done, modelOverrun, modelTimeout, 5'b0});
                modelOverrun = 1'b0;
                modelTimeout = 1'b0;
            end
        endcase
        driveRx(cmd);
    endtask

    task automatic alignCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (o_busy === 1'b0 && expQ.size() == 0 && i_tx_ready === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    // uart_tx model: every start must match the next expected reply byte.
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (o_tx_start === 1'b1) begin
                txByte = o_tx_data;
                startCount++;
                checkOutput("replyPresent", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    checkOutput("replyByte", 32'(txByte), 32'(expQ.pop_front()));
                end
                @(posedge clk);
                #1 i_tx_ready = 1'b0;
                @(negedge clk);
                checkOutput("txHold", 32'(o_tx_data), 32'(txByte));
                repeat (txBusy) @(posedge clk);
                #1 i_tx_ready = 1'b1;
            end
        end
    end

    // ADC model: answers each request after adcDelay cycles unless disabled.
    initial begin
        i_sample_valid = 1'b0;
        i_sample_data  = '0;
        forever begin
            @(negedge clk);
            if (o_sample_req === 1'b1) begin
                reqCount++;
                if (adcEnable) begin
                    repeat (adcDelay) @(posedge clk);
                    #1 i_sample_valid = 1'b1;
                    i_sample_data = nextSample;
                    @(posedge clk);
                    #1 i_sample_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rstTxStart", 32'(o_tx_start), 32'd0);
        checkOutput("rstTxData", 32'(o_tx_data), 32'd0);
        checkOutput("rstSampleReq", 32'(o_sample_req), 32'd0);
        checkOutput("rstGain", 32'(o_gain), 32'd0);
        checkOutput("rstBusy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;

        // PING: DECODE in N+1, start in N+2
        alignCycle();
        applyStimulus(8'h00, 16'h0);
        @(negedge clk);
        checkOutput("decodeBusyN1", 32'(o_busy), 32'd1);
        checkOutput("noStartN1", 32'(o_tx_start), 32'd0);
        @(negedge clk);
        checkOutput("pingStartN2", 32'(o_tx_start), 32'd1);
        waitIdle("pingIdle");

        // SET_GAIN 0x55: gain changes in N+2
        alignCycle();
        oldGain = modelGain;
        applyStimulus(8'h55, 16'h0);
        @(negedge clk);
        checkOutput("gainN1", 32'(o_gain), 32'(oldGain));
        @(negedge clk);
        checkOutput("gainN2", 32'(o_gain), 32'h15);
        waitIdle("setGainIdle");

        // SAMPLE with ADC ready: request in N+3, once
        i_adc_init_done = 1'b1;
        alignCycle();
        r0 = reqCount;
        applyStimulus(8'h80, 16'h1234);
        repeat (2) @(negedge clk);
        checkOutput("reqN2", 32'(o_sample_req), 32'd0);
        @(negedge clk);
        checkOutput("reqN3", 32'(o_sample_req), 32'd1);
        waitIdle("sampleIdle");
        checkOutput("reqOnce", 32'(reqCount), 32'(r0 + 1));

        // SAMPLE before ADC init
        i_adc_init_done = 1'b0;
        alignCycle();
        r0 = reqCount;
        applyStimulus(8'h80, 16'hBEEF);
        repeat (PRE_INIT_WAIT) @(negedge clk);
        checkOutput("noReqBeforeInit", 32'(reqCount), 32'(r0));
        checkOutput("busyBeforeInit", 32'(o_busy), 32'd1);
        i_adc_init_done = 1'b1;
        waitIdle("preInitIdle");
        checkOutput("reqAfterInit", 32'(reqCount), 32'(r0 + 1));

        // Overrun: SAMPLE, then two more back-to-back; the third byte is dropped
        adcDelay = 20;
        alignCycle();
        applyStimulus(8'h80, 16'hA55A);
        applyStimulus(8'h00, 16'h0);
        driveRx(8'h41);
        modelOverrun = 1'b1;
        waitIdle("overrunIdle");
        adcDelay = 2;
        checkOutput("gainAfterDrop", 32'(o_gain), 32'(modelGain));
        alignCycle();
        applyStimulus(8'hC0, 16'h0);
        waitIdle("status1Idle");
        alignCycle();
        applyStimulus(8'hC0, 16'h0);
        waitIdle("status2Idle");

        // Random commands against the reference model
        for (int n = 0; n < 24; n++) begin
            txBusy   = $urandom_range(1, 12);
            adcDelay = $urandom_range(1, 6);
            alignCycle();
            applyStimulus(8'($urandom), 16'($urandom));
            waitIdle("randIdle");
            checkOutput("randGain", 32'(o_gain), 32'(modelGain));
        end

`ifdef IAGC_CMD_TIMEOUT_EN
        // Timeout: no sample ever arrives
        adcEnable = 1'b0;
        alignCycle();
        expQ.push_back(8'hEE);
        modelTimeout = 1'b1;
        driveRx(8'h80);
        waitIdle("timeoutIdle");
        adcEnable = 1'b1;
        alignCycle();
        applyStimulus(8'hC0, 16'h0);
        waitIdle("timeoutStatusIdle");
`endif

        // Reset abort during TX_WAIT of the first sample byte
        txBusy = 10;
        alignCycle();
        s0 = startCount;
        applyStimulus(8'h80, 16'h5678);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (startCount == s0 + 1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("abortFirstByte", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("busyBeforeAbort", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        expQ.delete();
        modelGain    = '0;
        modelOverrun = 1'b0;
        modelTimeout = 1'b0;
        #1;
        checkOutput("abortTxStart", 32'(o_tx_start), 32'd0);
        checkOutput("abortTxData", 32'(o_tx_data), 32'd0);
        checkOutput("abortSampleReq", 32'(o_sample_req), 32'd0);
        checkOutput("abortGain", 32'(o_gain), 32'd0);
        checkOutput("abortBusy", 32'(o_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("noSecondByte", 32'(startCount), 32'(s0 + 1));
        txBusy = 3;
        alignCycle();
        applyStimulus(8'hC0, 16'h0);
        waitIdle("postResetIdle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
